// File: rtl/pc_ifid_stage_pkg.sv
// Shared definitions for the fetch stage: data width, reset/bubble
// constants, the fetch FSM state encoding and the PC alignment mask.
package pc_ifid_stage_pkg;

   localparam int unsigned XLEN = 32;

   localparam logic [XLEN-1:0] DEF_RESET_PC  = 32'h0000_0000;
   localparam logic [XLEN-1:0] DEF_NOP_INSTR = 32'h0000_0013;  // addi x0,x0,0

   // Clears the two low bits of a fetch address.
   localparam logic [XLEN-1:0] PC_ALIGN_MASK = ~XLEN'(3);

   // FETCH: request outstanding for pc. DISCARD: request outstanding for a
   // stale pc whose response must be dropped.
   typedef enum logic [0:0] {
      ST_FETCH   = 1'b0,
      ST_DISCARD = 1'b1
   } fetch_state_t;

endpackage

// File: rtl/pc_ifid_stage_ifid_reg.sv
// IF/ID pipeline register.
// Ports: clk, rst (async active-high); load captures {pc_d, instr_d} as a
// valid instruction; bubble writes NOP_INSTR with valid=0 and keeps ifid_pc;
// neither holds. bubble has priority over load.
module pc_ifid_stage_ifid_reg
   import pc_ifid_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            load,
   input  logic            bubble,
   input  logic [XLEN-1:0] pc_d,
   input  logic [XLEN-1:0] instr_d,
   output logic [XLEN-1:0] ifid_pc,
   output logic [XLEN-1:0] ifid_instr,
   output logic            ifid_valid
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ifid_pc    <= '0;
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
      end else if (bubble) begin
         ifid_instr <= NOP_INSTR;
         ifid_valid <= 1'b0;
      end else if (load) begin
         ifid_pc    <= pc_d;
         ifid_instr <= instr_d;
         ifid_valid <= 1'b1;
      end
   end

endmodule

// File: rtl/pc_ifid_stage.sv
// Fetch stage: holds the architectural PC, issues the instruction-memory
// request from it and fills the IF/ID register. A redirect that arrives
// while a fetch is still outstanding parks the target in redir_pc and drops
// the stale response when it finally returns (DISCARD state).
// Ports: clk, rst (async active-high); npc_in/flush/stall from next-PC logic
// and hazard unit; imem_rdata/imem_ready from instruction memory;
// imem_addr/imem_req to memory; pc_out back to next-PC logic;
// ifid_pc/ifid_instr/ifid_valid to decode; fetch_busy to hazard unit.
module pc_ifid_stage
   import pc_ifid_stage_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC  = DEF_RESET_PC,
   parameter logic [XLEN-1:0] NOP_INSTR = DEF_NOP_INSTR
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] npc_in,
   input  logic            flush,
   input  logic            stall,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            imem_ready,
   output logic [XLEN-1:0] imem_addr,
   output logic            imem_req,
   output logic [XLEN-1:0] pc_out,
   output logic [XLEN-1:0] ifid_pc,
   output logic [XLEN-1:0] ifid_instr,
   output logic            ifid_valid,
   output logic            fetch_busy
);

   fetch_state_t    state_q, state_nx;
   logic [XLEN-1:0] pc_q, pc_nx;
   logic [XLEN-1:0] redir_q, redir_nx;
   logic [XLEN-1:0] target;
   logic            ifid_load, ifid_bubble;

   assign target = npc_in & PC_ALIGN_MASK;

   // State, PC and parked redirect target.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_FETCH;
         pc_q    <= RESET_PC;
         redir_q <= '0;
      end else begin
         state_q <= state_nx;
         pc_q    <= pc_nx;
         redir_q <= redir_nx;
      end
   end

   // Next state, next PC and IF/ID control; flush outranks stall.
   always_comb begin
      state_nx    = state_q;
      pc_nx       = pc_q;
      redir_nx    = redir_q;
      ifid_load   = 1'b0;
      ifid_bubble = 1'b0;
      unique case (state_q)
         ST_FETCH: begin
            if (flush) begin
               ifid_bubble = 1'b1;
               if (imem_ready) begin
                  pc_nx = target;
               end else begin
                  // Keep imem_addr stable until the stale response returns.
                  redir_nx = target;
                  state_nx = ST_DISCARD;
               end
            end else if (imem_ready && !stall) begin
               ifid_load = 1'b1;
               pc_nx     = target;
            end else if (!imem_ready && !stall) begin
               ifid_bubble = 1'b1;
            end
         end
         ST_DISCARD: begin
            ifid_bubble = 1'b1;
            if (flush) begin
               redir_nx = target;
            end
            if (imem_ready) begin
               pc_nx    = flush ? target : redir_q;
               state_nx = ST_FETCH;
            end
         end
         default: begin
            state_nx = ST_FETCH;
         end
      endcase
   end

   assign imem_addr  = pc_q;
   assign pc_out     = pc_q;
   assign imem_req   = ~rst;
   assign fetch_busy = (state_q == ST_DISCARD) | ((state_q == ST_FETCH) & ~imem_ready);

   pc_ifid_stage_ifid_reg #(
      .NOP_INSTR (NOP_INSTR)
   ) u_ifid_reg (
      .clk        (clk),
      .rst        (rst),
      .load       (ifid_load),
      .bubble     (ifid_bubble),
      .pc_d       (pc_q),
      .instr_d    (imem_rdata),
      .ifid_pc    (ifid_pc),
      .ifid_instr (ifid_instr),
      .ifid_valid (ifid_valid)
   );

endmodule

// File: tb/tb_pc_ifid_stage.sv
// Self-checking bench for pc_ifid_stage: directed scenarios plus a random
// run checked against a transaction-level model of the fetch stage.
module tb_pc_ifid_stage;

   localparam logic [31:0] RST_PC = 32'h0000_0000;
   localparam logic [31:0] NOP    = 32'h0000_0013;

   logic        clk, rst;
   logic [31:0] npc_in, imem_rdata;
   logic        flush, stall, imem_ready;
   logic [31:0] imem_addr, pc_out, ifid_pc, ifid_instr;
   logic        imem_req, ifid_valid, fetch_busy;

   int n_checks = 0;
   int n_fail   = 0;

   // Model: architectural pc, a parked redirect (if a stale fetch is
   // pending) and the contents of the IF/ID slot.
   logic [31:0] m_pc, m_redir, m_ipc, m_instr;
   logic        m_stale, m_valid;

   pc_ifid_stage dut (
      .clk        (clk),
      .rst        (rst),
      .npc_in     (npc_in),
      .flush      (flush),
      .stall      (stall),
      .imem_rdata (imem_rdata),
      .imem_ready (imem_ready),
      .imem_addr  (imem_addr),
      .imem_req   (imem_req),
      .pc_out     (pc_out),
      .ifid_pc    (ifid_pc),
      .ifid_instr (ifid_instr),
      .ifid_valid (ifid_valid),
      .fetch_busy (fetch_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
   endfunction

   // Apply one cycle of inputs; memory answers for the model's pc.
   task automatic drive(input logic f, input logic s, input logic r,
                        input logic [31:0] n, input logic dead);
      flush      = f;
      stall      = s;
      imem_ready = r;
      npc_in     = n;
      imem_rdata = dead ? 32'hDEAD_BEEF : mem(m_pc);
      #1;
   endtask

   // Advance one clock and update the model from the inputs in force.
   task automatic tick();
      logic [31:0] tgt;
      @(posedge clk);
      tgt = {npc_in[31:2], 2'b00};
      if (rst) begin
         m_pc = RST_PC; m_redir = '0; m_stale = 1'b0;
         m_ipc = '0; m_instr = NOP; m_valid = 1'b0;
      end else if (m_stale || flush) begin
         m_instr = NOP; m_valid = 1'b0;
         if (flush) m_redir = tgt;
         if (imem_ready) begin
            m_pc = m_redir; m_stale = 1'b0;
         end else begin
            m_stale = 1'b1;
         end
      end else if (imem_ready && !stall) begin
         m_ipc = m_pc; m_instr = imem_rdata; m_valid = 1'b1; m_pc = tgt;
      end else if (!imem_ready && !stall) begin
         m_instr = NOP; m_valid = 1'b0;
      end
      #1;
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
      tick();
      rst = 1'b0;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b1, 32'h0, 1'b0);
      n_checks++; if (pc_out !== RST_PC) begin n_fail++; $display("FAIL reset_pc got %h want %h", pc_out, RST_PC); end
      n_checks++; if (imem_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %b want 0", imem_req); end
      n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
      n_checks++; if (ifid_instr !== NOP) begin n_fail++; $display("FAIL reset_instr got %h want %h", ifid_instr, NOP); end
      n_checks++; if (ifid_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ifid_pc got %h want 0", ifid_pc); end
      tick();
      rst = 1'b0;
      #1;
      n_checks++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL req_after_reset got %b want 1", imem_req); end
   endtask

   task automatic test_sequential();
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 1'b0, 1'b1, 32'(4 * i + 4), 1'b0);
         n_checks++; if (imem_addr !== 32'(4 * i)) begin n_fail++; $display("FAIL seq_addr%0d got %h want %h", i, imem_addr, 32'(4 * i)); end
         n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL seq_busy%0d got %b want 0", i, fetch_busy); end
         tick();
         n_checks++; if (ifid_pc !== 32'(4 * i) || ifid_instr !== mem(32'(4 * i)) || ifid_valid !== 1'b1) begin
            n_fail++; $display("FAIL seq_ifid%0d got %h/%h/%b want %h/%h/1", i, ifid_pc, ifid_instr, ifid_valid, 32'(4 * i), mem(32'(4 * i)));
         end
      end
   endtask

   task automatic test_stall();
      reset_dut();
      drive(1'b0, 1'b0, 1'b1, 32'h4, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b1, 32'h8, 1'b0); tick();
      for (int i = 0; i < 2; i++) begin
         drive(1'b0, 1'b1, 1'b1, 32'hC, 1'b0); tick();
         n_checks++; if (pc_out !== 32'h8) begin n_fail++; $display("FAIL stall_pc%0d got %h want 8", i, pc_out); end
         n_checks++; if (ifid_pc !== 32'h4 || ifid_instr !== mem(32'h4) || ifid_valid !== 1'b1) begin
            n_fail++; $display("FAIL stall_ifid%0d got %h/%h/%b want 4/%h/1", i, ifid_pc, ifid_instr, ifid_valid, mem(32'h4));
         end
      end
      drive(1'b0, 1'b0, 1'b1, 32'hC, 1'b0); tick();
      n_checks++; if (ifid_pc !== 32'h8 || ifid_instr !== mem(32'h8) || pc_out !== 32'hC) begin
         n_fail++; $display("FAIL stall_resume got %h/%h pc %h want 8/%h pc c", ifid_pc, ifid_instr, pc_out, mem(32'h8));
      end
   endtask

   task automatic test_flush_stalled();
      drive(1'b1, 1'b1, 1'b1, 32'h0000_0043, 1'b0); tick();
      n_checks++; if (pc_out !== 32'h40) begin n_fail++; $display("FAIL flush_stall_pc got %h want 40", pc_out); end
      n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
         n_fail++; $display("FAIL flush_stall_ifid got %h/%b want %h/0", ifid_instr, ifid_valid, NOP);
      end
   endtask

   task automatic test_discard();
      drive(1'b1, 1'b0, 1'b1, 32'h10, 1'b0); tick();
      drive(1'b1, 1'b0, 1'b0, 32'h80, 1'b0);
      n_checks++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL disc_busy_pre got %b want 1", fetch_busy); end
      tick();
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, i[0], (i == 2), $urandom, (i == 2));
         n_checks++; if (imem_addr !== 32'h10 || fetch_busy !== 1'b1 || ifid_valid !== 1'b0) begin
            n_fail++; $display("FAIL disc_hold%0d got addr %h busy %b valid %b want 10/1/0", i, imem_addr, fetch_busy, ifid_valid);
         end
         tick();
      end
      n_checks++; if (pc_out !== 32'h80 || ifid_valid !== 1'b0 || ifid_instr !== NOP) begin
         n_fail++; $display("FAIL disc_done got pc %h %h/%b want 80 %h/0", pc_out, ifid_instr, ifid_valid, NOP);
      end
   endtask

   task automatic test_double_flush();
      drive(1'b1, 1'b0, 1'b0, 32'h200, 1'b0); tick();
      drive(1'b1, 1'b0, 1'b0, 32'h100, 1'b0); tick();
      n_checks++; if (imem_addr !== 32'h80) begin n_fail++; $display("FAIL dbl_addr got %h want 80", imem_addr); end
      drive(1'b0, 1'b0, 1'b1, 32'h444, 1'b1); tick();
      n_checks++; if (pc_out !== 32'h100 || ifid_valid !== 1'b0) begin
         n_fail++; $display("FAIL dbl_target got pc %h valid %b want 100/0", pc_out, ifid_valid);
      end
   endtask

   task automatic test_reset_in_discard();
      drive(1'b1, 1'b0, 1'b0, 32'h300, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
      #2 rst = 1'b1;
      #1;
      n_checks++; if (pc_out !== RST_PC || ifid_valid !== 1'b0) begin
         n_fail++; $display("FAIL rst_async got pc %h valid %b want %h/0", pc_out, ifid_valid, RST_PC);
      end
      imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF;
      #1;
      n_checks++; if (fetch_busy !== 1'b0) begin n_fail++; $display("FAIL rst_state got busy %b want 0", fetch_busy); end
      tick();
      rst = 1'b0;
      #1;
      n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== NOP || pc_out !== RST_PC) begin
         n_fail++; $display("FAIL rst_late_ready got %h/%b pc %h want %h/0 pc %h", ifid_instr, ifid_valid, pc_out, NOP, RST_PC);
      end
      drive(1'b0, 1'b0, 1'b1, 32'h4, 1'b0); tick();
      n_checks++; if (ifid_pc !== RST_PC || ifid_instr !== mem(RST_PC) || ifid_valid !== 1'b1) begin
         n_fail++; $display("FAIL rst_refetch got %h/%h/%b want %h/%h/1", ifid_pc, ifid_instr, ifid_valid, RST_PC, mem(RST_PC));
      end
   endtask

   task automatic test_random();
      reset_dut();
      for (int i = 0; i < 400; i++) begin
         drive(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
               ($urandom_range(0, 3) != 0), $urandom, 1'b0);
         n_checks++; if (imem_addr !== m_pc || pc_out !== m_pc || fetch_busy !== (m_stale | ~imem_ready)) begin
            n_fail++; $display("FAIL rnd_pre%0d got addr %h pc %h busy %b want %h/%h/%b", i, imem_addr, pc_out, fetch_busy, m_pc, m_pc, m_stale | ~imem_ready);
         end
         tick();
         n_checks++; if (ifid_valid !== m_valid || ifid_instr !== m_instr || (m_valid && ifid_pc !== m_ipc) || imem_req !== 1'b1) begin
            n_fail++; $display("FAIL rnd_ifid%0d got %h/%h/%b req %b want %h/%h/%b", i, ifid_pc, ifid_instr, ifid_valid, imem_req, m_ipc, m_instr, m_valid);
         end
      end
   endtask

   initial begin
      rst = 1'b0; flush = 1'b0; stall = 1'b0; imem_ready = 1'b0;
      npc_in = '0; imem_rdata = '0;
      m_pc = RST_PC; m_redir = '0; m_stale = 1'b0;
      m_ipc = '0; m_instr = NOP; m_valid = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_sequential();
      test_stall();
      test_flush_stalled();
      test_discard();
      test_double_flush();
      test_reset_in_discard();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
